// File: rtl/drink_dispense_ctrl.sv
// Drink dispense controller: sequences the drink motor, the change ejector and
// the full-refund ejector for vend requests from the coin-accumulation FSM.
// It also tracks stock, holds one request that arrives while busy, and counts
// the drinks vended.
//
// Handshake: drink_in is a one-cycle request pulse with no back-pressure.
// change_in is meaningful only on the edge where drink_in is high. A request
// that cannot be served or held (pending already full) is dropped, and
// lost_req latches high until reset.
module drink_dispense_ctrl #(
  parameter int MOTOR_CYCLES  = 8,
  parameter int CHANGE_CYCLES = 4,
  parameter int REFUND_CYCLES = 6,
  parameter int STOCK_W       = 4,
  parameter int STOCK_INIT    = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               drink_in,
  input  logic               change_in,
  input  logic               restock,
  output logic               motor,
  output logic               change_out,
  output logic               refund,
  output logic               busy,
  output logic               empty,
  output logic [STOCK_W-1:0] stock,
  output logic [7:0]         vend_cnt,
  output logic               lost_req,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOTOR  = 2'd1,
    S_CHANGE = 2'd2,
    S_REFUND = 2'd3
  } state_t;

  localparam int CNT_MAX_A = (MOTOR_CYCLES > CHANGE_CYCLES) ? MOTOR_CYCLES : CHANGE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > REFUND_CYCLES) ? CNT_MAX_A : REFUND_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   MOTOR_LD  = CNT_W'(MOTOR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CHANGE_LD = CNT_W'(CHANGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   REFUND_LD = CNT_W'(REFUND_CYCLES - 1);
  localparam logic [STOCK_W-1:0] STOCK_LD  = STOCK_W'(STOCK_INIT);
  localparam logic [STOCK_W-1:0] STOCK_LD1 = STOCK_W'(STOCK_INIT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             job_chg_q;
  logic             pend_valid;
  logic             pend_chg;

  logic idle;
  logic take_job;
  logic job_chg;
  logic do_vend;

  assign idle      = (state == S_IDLE);
  assign empty     = (stock == '0);
  assign dbg_state = state;

  // Job selection in IDLE: the pending entry has priority over a fresh request.
  always_comb begin
    take_job = 1'b0;
    job_chg  = 1'b0;
    if (idle) begin
      if (pend_valid) begin
        take_job = 1'b1;
        job_chg  = pend_chg;
      end else if (drink_in) begin
        take_job = 1'b1;
        job_chg  = change_in;
      end
    end
  end

  // A started job vends only when there is stock; otherwise it becomes a refund.
  assign do_vend = take_job && (stock != '0);

  // Main sequencer: Moore outputs registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      job_chg_q  <= 1'b0;
      motor      <= 1'b0;
      change_out <= 1'b0;
      refund     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_job) begin
            busy <= 1'b1;
            if (stock != '0) begin
              state     <= S_MOTOR;
              motor     <= 1'b1;
              cnt       <= MOTOR_LD;
              job_chg_q <= job_chg;
            end else begin
              // Refund returns every coin, so the change flag is moot.
              state     <= S_REFUND;
              refund    <= 1'b1;
              cnt       <= REFUND_LD;
              job_chg_q <= 1'b0;
            end
          end
        end
        S_MOTOR: begin
          if (cnt == '0) begin
            motor <= 1'b0;
            if (job_chg_q) begin
              state      <= S_CHANGE;
              change_out <= 1'b1;
              cnt        <= CHANGE_LD;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_CHANGE: begin
          if (cnt == '0) begin
            state      <= S_IDLE;
            change_out <= 1'b0;
            busy       <= 1'b0;
            job_chg_q  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_REFUND: begin
          if (cnt == '0) begin
            state  <= S_IDLE;
            refund <= 1'b0;
            busy   <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          motor      <= 1'b0;
          change_out <= 1'b0;
          refund     <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // One-entry pending slot; refilled in the same IDLE cycle it is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_chg   <= 1'b0;
      lost_req   <= 1'b0;
    end else if (drink_in) begin
      if (idle && !pend_valid) begin
        pend_valid <= 1'b0;
      end else if (!pend_valid || idle) begin
        pend_valid <= 1'b1;
        pend_chg   <= change_in;
      end else begin
        lost_req <= 1'b1;
      end
    end else if (idle && pend_valid) begin
      pend_valid <= 1'b0;
    end
  end

  // Stock: restock wins but still accounts for a drink vended on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      stock <= STOCK_LD;
    end else if (restock) begin
      stock <= do_vend ? STOCK_LD1 : STOCK_LD;
    end else if (do_vend) begin
      stock <= stock - 1'b1;
    end
  end

  // Vend counter wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      vend_cnt <= 8'd0;
    end else if (do_vend) begin
      vend_cnt <= vend_cnt + 8'd1;
    end
  end

endmodule
